au_decode_stream: RTL and testbench

- Streaming binary-to-one-hot decoder, the inverse of the library's one-hot encoder.
- Takes a binary index on a valid/ready input channel and returns a WIDTH-bit one-hot word (bit `a` set) on a valid/ready output channel.
- Flags indices outside `0..WIDTH-1`.
- A 2-entry output buffer sustains one word per cycle under backpressure; `a_ready` is a function of registered state only, so there is no combinational `z_ready`→`a_ready` path.
- Used as the registered decode stage in front of select/shift datapaths.

---
 rtl/au_pkg.sv | 21 ++
 rtl/au_decode_core.sv | 25 ++
 rtl/au_decode_stream.sv | 106 ++++++++++
 tb/tb_au_decode_stream.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/au_pkg.sv
// Shared helpers for the au encoder/decoder family: index-width function and
// occupancy encodings for the 2-entry output buffers.
package au_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // max(ceil(log2(x)), 1)
    function automatic int unsigned clogb2(input int unsigned x);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(x)) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/au_decode_core.sv
// Combinational binary-to-one-hot decode; out-of-range indices give an all-zero
// word with err set.
module au_decode_core
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int unsigned IDXW = clogb2(32'(WIDTH))
) (
    input  logic [IDXW-1:0]  a,
    output logic [WIDTH-1:0] onehot,
    output logic             err
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a == IDXW'(i)) begin
                onehot[i] = 1'b1;
            end
        end
        // no bit matched means the index lies at or beyond WIDTH
        err = (onehot == '0);
    end

endmodule

// File: rtl/au_decode_stream.sv
// Registered streaming decoder: index in, one-hot word out through a 2-entry
// FIFO so a_ready depends only on registered occupancy.
module au_decode_stream
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int unsigned IDXW = clogb2(32'(WIDTH))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [IDXW-1:0]  a,
    output logic             z_valid,
    input  logic             z_ready,
    output logic [WIDTH-1:0] z,
    output logic             z_err
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "au_decode_stream: WIDTH must be >= 1");
    end

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        ONE   = ST_ONE,
        FULL  = ST_FULL
    } state_t;

    // entry layout: {err, data}
    localparam int unsigned EW = 32'(WIDTH) + 1;

    state_t          state, next_state;
    logic [EW-1:0]   e0, e1, next_e0, next_e1;
    logic [EW-1:0]   new_entry;
    logic [WIDTH-1:0] dec_word;
    logic            dec_err;
    logic            push, pop;

    au_decode_core #(.WIDTH(WIDTH)) u_core (
        .a      (a),
        .onehot (dec_word),
        .err    (dec_err)
    );

    assign new_entry = {dec_err, dec_word};

    assign a_ready = rst_n && (state != FULL);
    assign z_valid = (state != EMPTY);
    assign z       = z_valid ? e0[WIDTH-1:0] : '0;
    assign z_err   = z_valid & e0[EW-1];

    assign push = a_valid && a_ready;
    assign pop  = z_valid && z_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            e0    <= '0;
            e1    <= '0;
        end else begin
            state <= next_state;
            e0    <= next_e0;
            e1    <= next_e1;
        end
    end

    // e0 is always the head; a pop from FULL shifts e1 forward
    always_comb begin
        next_state = state;
        next_e0    = e0;
        next_e1    = e1;
        case (state)
            EMPTY: begin
                if (push) begin
                    next_state = ONE;
                    next_e0    = new_entry;
                end
            end
            ONE: begin
                if (push && pop) begin
                    next_e0 = new_entry;
                end else if (push) begin
                    next_state = FULL;
                    next_e1    = new_entry;
                end else if (pop) begin
                    next_state = EMPTY;
                    next_e0    = '0;
                end
            end
            FULL: begin
                if (pop) begin
                    next_state = ONE;
                    next_e0    = e1;
                    next_e1    = '0;
                end
            end
            default: begin
                next_state = EMPTY;
                next_e0    = '0;
                next_e1    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_au_decode_stream.sv
// Directed bench for au_decode_stream at WIDTH=8 and WIDTH=5.
module tb_au_decode_stream;

    logic       clk;
    logic       rst_n;

    logic       a_valid8, a_ready8, z_valid8, z_ready8, z_err8;
    logic [2:0] a8;
    logic [7:0] z8;

    logic       a_valid5, a_ready5, z_valid5, z_ready5, z_err5;
    logic [2:0] a5;
    logic [4:0] z5;

    int passed = 0;
    int total  = 0;

    au_decode_stream #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid8), .a_ready(a_ready8), .a(a8),
        .z_valid(z_valid8), .z_ready(z_ready8), .z(z8), .z_err(z_err8)
    );

    au_decode_stream #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid5), .a_ready(a_ready5), .a(a5),
        .z_valid(z_valid5), .z_ready(z_ready5), .z(z5), .z_err(z_err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic v, input logic [7:0] w,
                          input logic e, input logic r);
        check({tag, " z_valid"}, 32'(z_valid8), 32'(v));
        check({tag, " z"},       32'(z8),       32'(w));
        check({tag, " z_err"},   32'(z_err8),   32'(e));
        check({tag, " a_ready"}, 32'(a_ready8), 32'(r));
    endtask

    task automatic check5(input string tag, input logic v, input logic [4:0] w,
                          input logic e, input logic r);
        check({tag, " z_valid"}, 32'(z_valid5), 32'(v));
        check({tag, " z"},       32'(z5),       32'(w));
        check({tag, " z_err"},   32'(z_err5),   32'(e));
        check({tag, " a_ready"}, 32'(a_ready5), 32'(r));
    endtask

    initial begin
        logic [7:0] exp_word;
        rst_n    = 1'b0;
        a_valid8 = 1'b0; a8 = '0; z_ready8 = 1'b0;
        a_valid5 = 1'b0; a5 = '0; z_ready5 = 1'b0;

        // reset and idle
        step();
        check8("rst8", 1'b0, 8'h00, 1'b0, 1'b0);
        check5("rst5", 1'b0, 5'h00, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check8("idle8", 1'b0, 8'h00, 1'b0, 1'b1);
        check5("idle5", 1'b0, 5'h00, 1'b0, 1'b1);

        // streaming 0..7 with z_ready held high
        z_ready8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_valid8 = 1'b1;
            a8       = 3'(i);
            step();
            exp_word = 8'h01 << i;
            check8($sformatf("stream%0d", i), 1'b1, exp_word, 1'b0, 1'b1);
        end
        a_valid8 = 1'b0;
        step();
        check8("stream_drain", 1'b0, 8'h00, 1'b0, 1'b1);

        // out of range at WIDTH=5
        z_ready5 = 1'b1;
        a_valid5 = 1'b1;
        a5 = 3'd5;
        step();
        check5("oor5", 1'b1, 5'b00000, 1'b1, 1'b1);
        a5 = 3'd7;
        step();
        check5("oor7", 1'b1, 5'b00000, 1'b1, 1'b1);
        a5 = 3'd4;
        step();
        check5("inr4", 1'b1, 5'b10000, 1'b0, 1'b1);
        a_valid5 = 1'b0;
        step();
        check5("drain5", 1'b0, 5'b00000, 1'b0, 1'b1);

        // backpressure: 2 and 6 absorbed, 1 waits
        z_ready8 = 1'b0;
        a_valid8 = 1'b1;
        a8 = 3'd2;
        step();
        check8("bp_one", 1'b1, 8'h04, 1'b0, 1'b1);
        a8 = 3'd6;
        step();
        check8("bp_full", 1'b1, 8'h04, 1'b0, 1'b0);
        a8 = 3'd1;
        step();
        check8("bp_hold1", 1'b1, 8'h04, 1'b0, 1'b0);
        step();
        check8("bp_hold2", 1'b1, 8'h04, 1'b0, 1'b0);
        z_ready8 = 1'b1;
        step();
        check8("bp_pop1", 1'b1, 8'h40, 1'b0, 1'b1);
        step();
        check8("bp_pop2", 1'b1, 8'h02, 1'b0, 1'b1);
        a_valid8 = 1'b0;
        step();
        check8("bp_empty", 1'b0, 8'h00, 1'b0, 1'b1);

        // push and pop together in ONE
        z_ready8 = 1'b0;
        a_valid8 = 1'b1;
        a8 = 3'd3;
        step();
        check8("pp_one", 1'b1, 8'h08, 1'b0, 1'b1);
        a8 = 3'd5;
        z_ready8 = 1'b1;
        step();
        check8("pp_swap", 1'b1, 8'h20, 1'b0, 1'b1);
        a_valid8 = 1'b0;
        z_ready8 = 1'b0;
        step();
        check8("pp_hold", 1'b1, 8'h20, 1'b0, 1'b1);
        z_ready8 = 1'b1;
        step();
        check8("pp_empty", 1'b0, 8'h00, 1'b0, 1'b1);

        // reset while FULL discards both words
        z_ready8 = 1'b0;
        a_valid8 = 1'b1;
        a8 = 3'd0;
        step();
        a8 = 3'd7;
        step();
        check8("mr_full", 1'b1, 8'h01, 1'b0, 1'b0);
        a_valid8 = 1'b0;
        z_ready8 = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mr_ready_in_rst", 32'(a_ready8), 32'(1'b0));
        step();
        check8("mr_rst", 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check8("mr_after", 1'b0, 8'h00, 1'b0, 1'b1);
        step();
        check8("mr_after2", 1'b0, 8'h00, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
